branch_redirect_ctrl: RTL and testbench

//  Sequences the branch predictor around the IF/ID/EX pipeline. Tracks each fetched

---
 rtl/branch_redirect_ctrl_if.sv | 39 +++
 rtl/branch_redirect_ctrl.sv | 100 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: pipeline-side and BTB-training signals of the branch redirect controller
interface branch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             if_valid;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic [XLEN-1:0]  if_pred_target;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             upd_ready;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic [XLEN-1:0]  upd_target;
    logic             upd_taken;
    logic             flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             stall_req;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport slave (
        input  stall, if_valid, if_pc, if_pred_taken, if_pred_target,
               ex_is_branch, ex_taken, ex_target, upd_ready,
        output upd_valid, upd_pc, upd_target, upd_taken, flush, redirect_valid,
               redirect_pc, stall_req, branch_cnt, mispred_cnt
    );

    modport master (
        output stall, if_valid, if_pc, if_pred_taken, if_pred_target,
               ex_is_branch, ex_taken, ex_target, upd_ready,
        input  upd_valid, upd_pc, upd_target, upd_taken, flush, redirect_valid,
               redirect_pc, stall_req, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: tracks BTB predictions to EX, flushes/redirects on mispredict, queues BTB training writes
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_t;
    typedef struct packed {
        logic            v;
        logic [XLEN-1:0] pc;
        logic            pt;
        logic [XLEN-1:0] ptgt;
    } slot_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic            taken;
    } upd_t;

    state_t           state, state_nxt;
    slot_t            s_id, s_ex;
    upd_t             q0, q1, push_d;
    logic [1:0]       cnt;
    logic             resolve, taken_mis, nt_mis, mis, push, pop;
    logic [XLEN-1:0]  mis_pc, rpc;
    logic [CNT_W-1:0] b_cnt, m_cnt;

    // resolution, next state, training entry and output drive
    always_comb begin
        resolve       = s_ex.v && !bus.stall && state == RUN;
        taken_mis     = bus.ex_is_branch && bus.ex_taken && (!s_ex.pt || s_ex.ptgt != bus.ex_target);
        nt_mis        = s_ex.pt && !(bus.ex_is_branch && bus.ex_taken);
        mis           = resolve && (taken_mis || nt_mis);
        mis_pc        = taken_mis ? bus.ex_target : s_ex.pc + XLEN'(4);
        pop           = cnt != 2'd0 && bus.upd_ready;
        push          = resolve && (bus.ex_is_branch || s_ex.pt) && (cnt != 2'd2 || pop);
        push_d        = bus.ex_is_branch ? '{s_ex.pc, bus.ex_target, bus.ex_taken} : '{s_ex.pc, s_ex.pc, 1'b0};
        state_nxt     = mis ? FLUSH : RUN;
        bus.flush          = state == FLUSH;
        bus.redirect_valid = state == FLUSH;
        bus.redirect_pc    = rpc;
        bus.upd_valid      = cnt != 2'd0;
        bus.upd_pc         = q0.pc;
        bus.upd_target     = q0.tgt;
        bus.upd_taken      = q0.taken;
        bus.stall_req      = cnt == 2'd2 && !pop;
        bus.branch_cnt     = b_cnt;
        bus.mispred_cnt    = m_cnt;
    end

    // FSM state register and the redirect address captured with the mispredict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            rpc   <= '0;
        end else begin
            state <= state_nxt;
            if (mis) rpc <= mis_pc;
        end
    end

    // prediction tracking through ID and EX; a flush discards both as wrong-path
    always_ff @(posedge clk or posedge rst) begin
        if (rst || state == FLUSH) begin
            s_id <= '0;
            s_ex <= '0;
        end else if (!bus.stall) begin
            s_ex <= s_id;
            s_id <= '{bus.if_valid, bus.if_pc, bus.if_pred_taken, bus.if_pred_target};
        end
    end

    // two-entry training FIFO, q0 is always the head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0  <= '0;
            q1  <= '0;
            cnt <= '0;
        end else begin
            if (pop) q0 <= (push && cnt == 2'd1) ? push_d : q1;
            else if (push && cnt == 2'd0) q0 <= push_d;
            if (push && (pop ? cnt == 2'd2 : cnt == 2'd1)) q1 <= push_d;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_cnt <= '0;
            m_cnt <= '0;
        end else begin
            b_cnt <= b_cnt + CNT_W'(resolve && bus.ex_is_branch && b_cnt != '1);
            m_cnt <= m_cnt + CNT_W'(mis && m_cnt != '1);
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random stimulus against an instruction-level reference model
module tb_branch_redirect_ctrl;
    logic clk = 0, rst = 0, tb_stall = 0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bif();
    assign bif.stall = tb_stall | bif.stall_req;

    branch_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct {logic v; logic [31:0] pc; logic [31:0] tgt; logic pt;} ins_t;
    typedef struct {logic [31:0] pc; logic [31:0] tgt; logic tk;} wr_t;

    ins_t        m_id, m_ex;
    wr_t         mq[$];
    bit          m_fl;
    logic [31:0] m_rpc;
    int          m_b, m_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_id  = '{1'b0, 32'h0, 32'h0, 1'b0};
        m_ex  = m_id;
        mq    = {};
        m_fl  = 0;
        m_rpc = 0;
        m_b   = 0;
        m_m   = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flush"}, bif.flush, m_fl);
        chk({tag, ".rvalid"}, bif.redirect_valid, m_fl);
        if (m_fl) chk({tag, ".rpc"}, bif.redirect_pc, m_rpc);
        chk({tag, ".uvalid"}, bif.upd_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({tag, ".upc"}, bif.upd_pc, mq[0].pc);
            chk({tag, ".utgt"}, bif.upd_target, mq[0].tgt);
            chk({tag, ".utk"}, bif.upd_taken, mq[0].tk);
        end
        chk({tag, ".stallreq"}, bif.stall_req, mq.size() == 2 && !bif.upd_ready);
        chk({tag, ".bcnt"}, bif.branch_cnt, 64'(m_b));
        chk({tag, ".mcnt"}, bif.mispred_cnt, 64'(m_m));
    endtask

    task automatic cyc(input string tag, input logic iv, input logic [31:0] ipc, input logic ipt,
                       input logic [31:0] itgt, input logic eb, input logic et, input logic [31:0] etgt,
                       input logic rdy, input logic st);
        bit se, res, mis;
        logic [31:0] tg;
        @(negedge clk);
        bif.if_valid = iv; bif.if_pc = ipc; bif.if_pred_taken = ipt; bif.if_pred_target = itgt;
        bif.ex_is_branch = eb; bif.ex_taken = et; bif.ex_target = etgt;
        bif.upd_ready = rdy; tb_stall = st;
        se  = st || (mq.size() == 2 && !rdy);
        res = m_ex.v && !se && !m_fl;
        mis = 0;
        tg  = 0;
        if (res && eb && et && (!m_ex.pt || m_ex.tgt != etgt)) begin
            mis = 1; tg = etgt;
        end else if (res && m_ex.pt && !(eb && et)) begin
            mis = 1; tg = m_ex.pc + 32'd4;
        end
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (res && eb) begin
            mq.push_back('{m_ex.pc, etgt, et});
            if (m_b < 65535) m_b++;
        end else if (mis) mq.push_back('{m_ex.pc, m_ex.pc, 1'b0});
        if (mis) begin
            if (m_m < 65535) m_m++;
            m_rpc = tg;
        end
        if (m_fl) begin
            m_id.v = 0; m_ex.v = 0;
        end else if (!se) begin
            m_ex = m_id;
            m_id = '{iv, ipc, itgt, ipt};
        end
        m_fl = mis;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input logic rdy);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        bif.if_valid = 0; bif.if_pc = 0; bif.if_pred_taken = 0; bif.if_pred_target = 0;
        bif.ex_is_branch = 0; bif.ex_taken = 0; bif.ex_target = 0; bif.upd_ready = 0;
        m_reset();
        #1 rst = 1;
        @(posedge clk);
        #1 check_all("reset");
        chk("reset.rpc", bif.redirect_pc, 0);
        @(negedge clk) rst = 0;

        // correctly predicted taken branch
        cyc("t1.inj", 1, 32'h100, 1, 32'h200, 0, 0, 0, 1, 0);
        idle(1);
        cyc("t1.res", 0, 0, 0, 0, 1, 1, 32'h200, 0, 0);
        chk("t1.noflush", bif.flush, 0);
        chk("t1.upc", bif.upd_pc, 32'h100);
        chk("t1.utgt", bif.upd_target, 32'h200);
        chk("t1.bcnt", bif.branch_cnt, 1);
        idle(1);

        // predicted taken, resolved untaken
        cyc("t2.inj", 1, 32'h40, 1, 32'h80, 0, 0, 0, 1, 0);
        idle(1);
        cyc("t2.res", 0, 0, 0, 0, 1, 0, 32'h0, 1, 0);
        chk("t2.flush", bif.flush, 1);
        chk("t2.rpc", bif.redirect_pc, 32'h44);
        chk("t2.mcnt", bif.mispred_cnt, 1);
        idle(1);
        chk("t2.flush_end", bif.flush, 0);

        // wrong target, then a would-be mispredict during FLUSH that must be ignored
        cyc("t3.inj0", 1, 32'h80, 1, 32'h300, 0, 0, 0, 1, 0);
        cyc("t3.inj1", 1, 32'h90, 1, 32'h500, 0, 0, 0, 1, 0);
        cyc("t3.res", 0, 0, 0, 0, 1, 1, 32'h380, 1, 0);
        chk("t3.rpc", bif.redirect_pc, 32'h380);
        cyc("t3.wrongpath", 0, 0, 0, 0, 1, 0, 32'h0, 1, 0);
        chk("t3.ignored", bif.flush, 0);
        chk("t3.mcnt", bif.mispred_cnt, 2);
        idle(1);

        // training backpressure
        cyc("t4.a", 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4.b", 1, 32'h1004, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4.c", 1, 32'h1008, 0, 0, 1, 0, 0, 0, 0);
        cyc("t4.resb", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t4.full", bif.stall_req, 1);
        cyc("t4.hold", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t4.held_bcnt", bif.branch_cnt, 5);
        cyc("t4.release", 0, 0, 0, 0, 1, 0, 0, 1, 0);
        chk("t4.head", bif.upd_pc, 32'h1004);
        idle(1);
        chk("t4.last", bif.upd_pc, 32'h1008);
        idle(1);
        idle(1);

        // alias with PC wraparound
        cyc("t5.inj", 1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0, 1, 0);
        idle(1);
        cyc("t5.res", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5.rpc", bif.redirect_pc, 32'h0);
        chk("t5.upc", bif.upd_target, 32'hFFFF_FFFC);
        chk("t5.utk", bif.upd_taken, 0);
        idle(1);
        idle(1);

        // async reset during FLUSH with two queued writes
        cyc("t6.a", 1, 32'h2000, 0, 0, 0, 0, 0, 0, 0);
        cyc("t6.b", 1, 32'h2004, 1, 32'h3000, 0, 0, 0, 0, 0);
        cyc("t6.resa", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t6.resb", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t6.inflush", bif.flush, 1);
        chk("t6.full", bif.stall_req, 1);
        #2 rst = 1;
        #1;
        m_reset();
        check_all("t6.async");
        chk("t6.rpc", bif.redirect_pc, 0);
        @(negedge clk) rst = 0;
        idle(1);
        chk("t6.empty", bif.upd_valid, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, pt, et;
            pc = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : 32'h4000 + 32'($urandom_range(0, 15)) * 4;
            pt = 32'h100 * $urandom_range(1, 3);
            et = 32'h100 * $urandom_range(1, 3);
            cyc("rnd", $urandom % 4 != 0, pc, 1'($urandom), pt, 1'($urandom), 1'($urandom), et,
                $urandom % 3 != 0, $urandom % 8 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
